// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: command codes, default timing values and the
// fixed-priority arbiter used by the move scheduler.
package tetris_pkg;

  typedef enum logic [2:0] {
    CMD_NONE    = 3'd0,
    CMD_LEFT    = 3'd1,
    CMD_RIGHT   = 3'd2,
    CMD_ROTATE  = 3'd3,
    CMD_DOWN    = 3'd4,
    CMD_GRAVITY = 3'd5
  } cmd_e;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_e;

  localparam int DAS_CYCLES_DEF     = 16;
  localparam int ARR_CYCLES_DEF     = 4;
  localparam int GRAVITY_CYCLES_DEF = 25000000;

  // Source slots in the pending vector
  localparam int NUM_SRC   = 5;
  localparam int SRC_ROT   = 0;
  localparam int SRC_LEFT  = 1;
  localparam int SRC_RIGHT = 2;
  localparam int SRC_DOWN  = 3;
  localparam int SRC_GRAV  = 4;

  typedef struct packed {
    cmd_e               cmd;
    logic [NUM_SRC-1:0] gnt;
  } grant_t;

  // ROTATE > LEFT > RIGHT > DOWN > GRAVITY
  function automatic grant_t arbitrate(input logic [NUM_SRC-1:0] req);
    grant_t g;
    g.cmd = CMD_NONE;
    g.gnt = '0;
    if (req[SRC_ROT]) begin
      g.cmd = CMD_ROTATE;  g.gnt[SRC_ROT] = 1'b1;
    end else if (req[SRC_LEFT]) begin
      g.cmd = CMD_LEFT;    g.gnt[SRC_LEFT] = 1'b1;
    end else if (req[SRC_RIGHT]) begin
      g.cmd = CMD_RIGHT;   g.gnt[SRC_RIGHT] = 1'b1;
    end else if (req[SRC_DOWN]) begin
      g.cmd = CMD_DOWN;    g.gnt[SRC_DOWN] = 1'b1;
    end else if (req[SRC_GRAV]) begin
      g.cmd = CMD_GRAVITY; g.gnt[SRC_GRAV] = 1'b1;
    end
    return g;
  endfunction

endpackage

// File: rtl/move_scheduler_repeat_timer.sv
// Per-direction auto-repeat: initial delay of DAS_CYCLES while held, then a
// fire pulse every ARR_CYCLES until the button is released.
module repeat_timer
  import tetris_pkg::*;
#(
  parameter int DAS_CYCLES = DAS_CYCLES_DEF,
  parameter int ARR_CYCLES = ARR_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic held,
  input  logic start,
  input  logic force_idle,
  output logic fire
);

  localparam int CMAX = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;

  rpt_state_e    state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RPT_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    fire    = 1'b0;
    unique case (state_q)
      RPT_IDLE: begin
        if (start) begin
          state_n = RPT_DELAY;
          cnt_n   = '0;
        end
      end
      RPT_DELAY: begin
        if (!held) begin
          state_n = RPT_IDLE;
          cnt_n   = '0;
        end else if (cnt_q == CW'(DAS_CYCLES - 1)) begin
          state_n = RPT_REPEAT;
          cnt_n   = '0;
          fire    = 1'b1;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      RPT_REPEAT: begin
        if (!held) begin
          state_n = RPT_IDLE;
          cnt_n   = '0;
        end else if (cnt_q == CW'(ARR_CYCLES - 1)) begin
          cnt_n = '0;
          fire  = 1'b1;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      default: begin
        state_n = RPT_IDLE;
        cnt_n   = '0;
      end
    endcase
    // Pause and left/right conflict park the timer without producing repeats
    if (force_idle) begin
      state_n = RPT_IDLE;
      cnt_n   = '0;
      fire    = 1'b0;
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// Merges button presses, auto-repeat and the gravity timer into a single
// valid/ready command stream with one-deep coalescing per source.
module move_scheduler
  import tetris_pkg::*;
#(
  parameter int DAS_CYCLES     = DAS_CYCLES_DEF,
  parameter int ARR_CYCLES     = ARR_CYCLES_DEF,
  parameter int GRAVITY_CYCLES = GRAVITY_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause,
  input  logic       down_signal,
  input  logic       rotate_signal,
  input  logic       right_signal,
  input  logic       left_signal,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd
);

  localparam int GW = $clog2(GRAVITY_CYCLES);

  logic [3:0]         btn, smp_q, hist_q, rise, rep_fire;
  logic               conflict;
  logic [NUM_SRC-1:0] pend_q, pend_n, events, req;
  logic [GW-1:0]      grav_q;
  logic               grav_tick, xfer, down_xfer, load;
  logic               vld_q;
  cmd_e               cmd_q;
  grant_t             arb;

  assign btn = {down_signal, right_signal, left_signal, rotate_signal};

  // History resets high so a button held across reset release is not a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_q  <= '1;
      hist_q <= '1;
    end else begin
      smp_q  <= btn;
      hist_q <= smp_q;
    end
  end

  assign rise     = smp_q & ~hist_q;
  assign conflict = smp_q[SRC_LEFT] & smp_q[SRC_RIGHT];

  assign rep_fire[SRC_ROT] = 1'b0;

  for (genvar g = SRC_LEFT; g <= SRC_DOWN; g++) begin : g_rpt
    localparam bit LR = (g != SRC_DOWN);
    repeat_timer #(
      .DAS_CYCLES(DAS_CYCLES),
      .ARR_CYCLES(ARR_CYCLES)
    ) u_rpt (
      .clk       (clk),
      .rst       (rst),
      .held      (smp_q[g]),
      .start     (rise[g]),
      .force_idle(pause | (LR & conflict)),
      .fire      (rep_fire[g])
    );
  end

  assign xfer      = vld_q & cmd_ready;
  assign down_xfer = xfer & (cmd_q == CMD_DOWN);
  assign grav_tick = (grav_q == GW'(GRAVITY_CYCLES - 1)) & ~pause & ~down_xfer;
  assign events    = {grav_tick, rise | rep_fire};

  // A DOWN leaving this cycle makes any pending gravity redundant
  always_comb begin
    req = pend_q;
    if (down_xfer) req[SRC_GRAV] = 1'b0;
  end

  assign arb  = arbitrate(req);
  assign load = (~vld_q | xfer) & ~pause & (|req);

  always_comb begin
    pend_n = req;
    if (load) pend_n = pend_n & ~arb.gnt;
    pend_n = pend_n | events;
    if (pause) pend_n = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      grav_q <= '0;
    else if (down_xfer)                           grav_q <= '0;
    else if (!pause) begin
      if (grav_q == GW'(GRAVITY_CYCLES - 1))      grav_q <= '0;
      else                                        grav_q <= grav_q + GW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      cmd_q <= CMD_NONE;
    end else if (load) begin
      vld_q <= 1'b1;
      cmd_q <= arb.cmd;
    end else if (xfer) begin
      vld_q <= 1'b0;
      cmd_q <= CMD_NONE;
    end
  end

  assign cmd_valid = vld_q;
  assign cmd       = cmd_q;

endmodule

// File: doc/move_scheduler.md
MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 Parameters SHALL be, one per line:
  DAS_CYCLES, 16, clocks a direction input must stay held before auto-repeat starts (>=2)
  ARR_CYCLES, 4, clocks between auto-repeat commands (>=1)
  GRAVITY_CYCLES, 25000000, clocks between gravity commands (>=2)
REQ-002 Ports SHALL be:
  clk  in  1  system clock, 50 MHz
  rst  in  1  reset, asynchronous, active-high
  pause  in  1  level; high = game paused
  down_signal  in  1  debounced DOWN button level from input_handler
  rotate_signal  in  1  debounced ROTATE button level from input_handler
  right_signal  in  1  debounced RIGHT button level from input_handler
  left_signal  in  1  debounced LEFT button level from input_handler
  cmd_ready  in  1  game logic accepts cmd this cycle
  cmd_valid  out  1  cmd holds a command
  cmd  out  3  command code (REQ-004)

Function
REQ-003 The block SHALL merge the four button sources and an internal gravity timer into one valid/ready command stream.
REQ-004 Command codes SHALL be NONE=0, LEFT=1, RIGHT=2, ROTATE=3, DOWN=4, GRAVITY=5; codes 6-7 are unused and never driven.
REQ-005 Each source SHALL have a one-bit pending flag; a new event on a source whose flag is already set SHALL be coalesced (no queueing).
REQ-006 A rising edge of any button level, sampled on clk, SHALL set that source's pending flag one cycle after the first edge at which the level is sampled high.
REQ-007 With the output register empty, the highest-priority pending source SHALL be loaded into cmd with cmd_valid high the cycle after its flag sets (press-to-valid latency 2 cycles).
REQ-008 Priority SHALL be ROTATE > LEFT > RIGHT > DOWN > GRAVITY.
REQ-009 A transfer SHALL occur when cmd_valid and cmd_ready are both high; the granted source's pending flag clears on load into the output register.
REQ-010 Once cmd_valid is high, cmd and cmd_valid SHALL stay stable until the transfer, regardless of new events or pause.
REQ-011 On a transfer cycle, the next pending command SHALL load the same cycle (back-to-back, one command per clock).
REQ-012 An event on the same cycle its flag is cleared by a grant SHALL leave the flag set (set wins).
REQ-013 LEFT, RIGHT and DOWN SHALL auto-repeat with states IDLE, DELAY, REPEAT:
  IDLE->DELAY on rising edge, counter=0;
  DELAY->REPEAT when held DAS_CYCLES clocks, setting pending;
  in REPEAT, pending set every ARR_CYCLES clocks while held;
  any state->IDLE when level falls.
REQ-014 ROTATE SHALL NOT auto-repeat: one command per press.
REQ-015 If left_signal and right_signal are both high, both repeat FSMs SHALL hold in IDLE; edges still set pending once.
REQ-016 The gravity counter SHALL count 0..GRAVITY_CYCLES-1; at terminal count it sets GRAVITY pending and wraps to 0.
REQ-017 A transfer of DOWN SHALL reset the gravity counter to 0 and clear GRAVITY pending.
REQ-018 While pause is high: all pending flags clear, repeat FSMs force IDLE, and the gravity counter holds its value; no new command loads (REQ-010 still applies).
REQ-019 Buttons held through pause deassertion SHALL NOT produce commands until released and pressed again.

Reset
REQ-020 On rst high, asynchronously: cmd_valid=0, cmd=NONE, all pending flags=0, repeat FSMs=IDLE, all counters=0, edge-detect history=1 so buttons held at reset release generate no event.
REQ-021 Reset mid-transfer SHALL drop the in-flight command without a transfer.

Structure
REQ-022 Command code constants and default parameter values SHALL live in the shared Tetris package (tetris_pkg) used by the game logic.
REQ-023 The per-direction DELAY/REPEAT FSM with its counter SHALL be one sub-module, repeat_timer, instantiated three times (left, right, down).

Verification (DAS_CYCLES=4, ARR_CYCLES=2, GRAVITY_CYCLES=20, cmd_ready=1 unless stated)
REQ-024 Single ROTATE press, held 10 cycles -> exactly one cmd=3 pulse, cmd_valid high 2 cycles after first high sample.
REQ-025 LEFT held 12 cycles -> cmd=1 at press, again after 4 cycles, then every 2 cycles until release; none after release.
REQ-026 ROTATE and LEFT rise on the same cycle -> cmd=3 then cmd=1 on consecutive cycles.
REQ-027 cmd_ready=0 for 5 cycles with RIGHT pending, then ROTATE press -> cmd stays 2 until ready, then 3 next cycle.
REQ-028 Idle 20 cycles -> cmd=5; DOWN transferred at cycle 15 -> next cmd=5 only 20 cycles after that transfer.
REQ-029 pause high with DOWN held and gravity at 10 -> no new command; after pause low, gravity fires 10 cycles later and DOWN stays silent until re-pressed.
